// File: rtl/ir_pkg.sv
// Shared constants and types for the instruction register queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ir_pkg;

    localparam int IR_WIDTH = 12;

    typedef logic [IR_WIDTH-1:0] instr_t;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector for a single-bit level input (button, strobe).
// Latency: rise is combinational from in and a 1-cycle registered copy of in.
// Backpressure: none; a level held high yields exactly one rise pulse.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic in_q;

    // History register; cleared on reset so a level already high after reset counts as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign rise = in && !in_q;

endmodule

// File: rtl/ir_queue.sv
// Instruction register queue: captures one of NSRC words on load into a DEPTH-entry FIFO.
// Latency: load to q 1 cycle when empty; pop to next head 1 cycle; outputs from registered state only.
// Backpressure: push while full without pop is dropped and sets sticky ovf. Macro IR_QUEUE_EDGE_EN pushes on load rising edge only.
module ir_queue
    import ir_pkg::*;
#(
    parameter int WIDTH = IR_WIDTH,
    parameter int DEPTH = 4,
    parameter int NSRC  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [$clog2(NSRC)-1:0]    sel,
    input  logic [NSRC*WIDTH-1:0]      d,
    input  logic                       pop,
    input  logic                       clr_ovf,
    output logic [WIDTH-1:0]           q,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(NSRC);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             ovf_r;
    logic             push_req;
    logic             push_acc;
    logic             pop_acc;
    logic             drop;
    logic [WIDTH-1:0] word;

`ifdef IR_QUEUE_EDGE_EN
    edge_det u_load_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (load),
        .rise (push_req)
    );
`else
    assign push_req = load;
`endif

    // Source mux; any select outside 0..NSRC-1 falls back to source 0.
    always_comb begin
        word = d[WIDTH-1:0];
        for (int k = 1; k < NSRC; k++) begin
            if (sel == SW'(k)) begin
                word = d[k*WIDTH +: WIDTH];
            end
        end
    end

    assign valid    = (cnt != '0);
    assign full     = (cnt == CW'(DEPTH));
    assign pop_acc  = pop && valid;
    assign push_acc = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && push_acc) begin
            mem[wr_ptr] <= word;
        end
    end

    // Pointers, explicit occupancy and sticky overflow (a drop beats a same-cycle clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_r  <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_acc, pop_acc})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (drop) begin
                ovf_r <= 1'b1;
            end else if (clr_ovf) begin
                ovf_r <= 1'b0;
            end
        end
    end

    assign q     = valid ? mem[rd_ptr] : '0;
    assign count = cnt;
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_ir_queue.sv
module tb_ir_queue;

    localparam int WIDTH = 12;
    localparam int DEPTH = 4;
    localparam int NSRC  = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  load;
    logic [0:0]            sel;
    logic [NSRC*WIDTH-1:0] d;
    logic                  pop;
    logic                  clr_ovf;
    logic [WIDTH-1:0]      q;
    logic                  valid;
    logic                  full;
    logic [2:0]            count;
    logic                  ovf;

    int passed = 0;
    int total  = 0;

    // Scoreboard: words expected at the head, oldest first.
    logic [WIDTH-1:0] sb[$];
    logic             m_ovf;
    logic             m_load_q;

    ir_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NSRC(NSRC)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .sel     (sel),
        .d       (d),
        .pop     (pop),
        .clr_ovf (clr_ovf),
        .q       (q),
        .valid   (valid),
        .full    (full),
        .count   (count),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag);
        logic [WIDTH-1:0] head;
        head = (sb.size() > 0) ? sb[0] : '0;
        chk({tag, ".q"},     32'(q),     32'(head));
        chk({tag, ".count"}, 32'(count), 32'(sb.size()));
        chk({tag, ".valid"}, 32'(valid), 32'(sb.size() > 0));
        chk({tag, ".full"},  32'(full),  32'(sb.size() == DEPTH));
        chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
    endtask

    // One clock: drive at negedge, update the reference at posedge, check 1 time unit later.
    task automatic step(input string tag, input logic ld, input logic s,
                        input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                        input logic pp, input logic cl, input logic r);
        logic preq, pacc, oacc;
        logic [WIDTH-1:0] w;
        @(negedge clk);
        rst = r; load = ld; sel = s; d = {w1, w0}; pop = pp; clr_ovf = cl;
        @(posedge clk);
        if (r) begin
            sb.delete();
            m_ovf    = 1'b0;
            m_load_q = 1'b0;
        end else begin
`ifdef IR_QUEUE_EDGE_EN
            preq = ld && !m_load_q;
`else
            preq = ld;
`endif
            w    = s ? w1 : w0;
            oacc = pp && (sb.size() > 0);
            pacc = preq && ((sb.size() < DEPTH) || pp);
            if (preq && (sb.size() == DEPTH) && !pp) m_ovf = 1'b1;
            else if (cl)                             m_ovf = 1'b0;
            if (oacc) void'(sb.pop_front());
            if (pacc) sb.push_back(w);
            m_load_q = ld;
        end
        #1;
        chk_all(tag);
    endtask

    task automatic push1(input string tag, input logic [WIDTH-1:0] w);
        step(tag, 1'b1, 1'b1, 12'h000, w, 1'b0, 1'b0, 1'b0);
        step({tag, "_idle"}, 1'b0, 1'b1, 12'h000, w, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop1(input string tag);
        step(tag, 1'b0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; sel = 1'b0; d = '0; pop = 1'b0; clr_ovf = 1'b0;
        sb.delete(); m_ovf = 1'b0; m_load_q = 1'b0;

        // Reset and idle
        step("rst0", 1'b0, 1'b0, 12'h0, 12'h0, 1'b0, 1'b0, 1'b1);
        step("rst1", 1'b0, 1'b0, 12'h0, 12'h0, 1'b0, 1'b0, 1'b1);
        step("idle", 1'b0, 1'b0, 12'h0, 12'h0, 1'b0, 1'b0, 1'b0);
        chk("reset_q", 32'(q), 32'h0);
        chk("reset_count", 32'(count), 32'h0);

        // Fill with source 1
        push1("fill1", 12'hA01);
        chk("first_visible", 32'(q), 32'hA01);
        push1("fill2", 12'hA02);
        push1("fill3", 12'hA03);
        push1("fill4", 12'hA04);
        chk("filled_count", 32'(count), 32'd4);
        chk("filled_full", 32'(full), 32'd1);

        // Overflow, clear, and drop racing a clear
        push1("drop", 12'hBBB);
        chk("drop_ovf", 32'(ovf), 32'd1);
        chk("drop_head", 32'(q), 32'hA01);
        step("clr", 1'b0, 1'b0, 12'h0, 12'h0, 1'b0, 1'b1, 1'b0);
        chk("clr_ovf", 32'(ovf), 32'd0);
        step("drop_clr", 1'b1, 1'b1, 12'h0, 12'hBBB, 1'b0, 1'b1, 1'b0);
        chk("drop_clr_ovf", 32'(ovf), 32'd1);
        step("clr2", 1'b0, 1'b0, 12'h0, 12'h0, 1'b0, 1'b1, 1'b0);

        // Full push+pop, then enough traffic to wrap both pointers twice
        step("pp_full", 1'b1, 1'b1, 12'h0, 12'hC00, 1'b1, 1'b0, 1'b0);
        chk("pp_full_count", 32'(count), 32'd4);
        chk("pp_full_head", 32'(q), 32'hA02);
        for (int i = 1; i < 10; i++) begin
            step("pp_idle", 1'b0, 1'b0, 12'h0, 12'h0, 1'b0, 1'b0, 1'b0);
            step("pp_wrap", 1'b1, 1'b1, 12'h0, 12'(12'hC00 + i), 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) pop1("drain");
        chk("drained_valid", 32'(valid), 32'd0);
        pop1("empty_pop");

        // Held load: one push with edge detection, level mode fills and overflows
        step("rst_e", 1'b0, 1'b0, 12'h0, 12'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step("hold", 1'b1, 1'b0, 12'h123, 12'h0, 1'b0, 1'b0, 1'b0);
`ifdef IR_QUEUE_EDGE_EN
        chk("hold_count", 32'(count), 32'd1);
        chk("hold_ovf", 32'(ovf), 32'd0);
`else
        chk("hold_count", 32'(count), 32'd4);
        chk("hold_ovf", 32'(ovf), 32'd1);
`endif
        chk("hold_head", 32'(q), 32'h123);

        // Mid-operation reset, empty pop, push+pop on empty
        step("rst_m", 1'b0, 1'b0, 12'h0, 12'h0, 1'b0, 1'b0, 1'b1);
        push1("m1", 12'h501);
        push1("m2", 12'h502);
        chk("m_count2", 32'(count), 32'd2);
        step("rst_mid", 1'b1, 1'b1, 12'h0, 12'h777, 1'b1, 1'b0, 1'b1);
        step("after_rst", 1'b0, 1'b0, 12'h0, 12'h0, 1'b0, 1'b0, 1'b0);
        chk("after_rst_count", 32'(count), 32'd0);
        chk("after_rst_q", 32'(q), 32'h0);
        pop1("empty_pop2");
        step("pp_empty", 1'b1, 1'b1, 12'h0, 12'h9AB, 1'b1, 1'b0, 1'b0);
        chk("pp_empty_count", 32'(count), 32'd1);
        chk("pp_empty_q", 32'(q), 32'h9AB);
        step("end_idle", 1'b0, 1'b0, 12'h0, 12'h0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction register queue: the successor to the single-word instruction register. Captures one of NSRC candidate instruction words on a load strobe (the debounced button pulse) into a DEPTH-entry FIFO and presents the oldest entry to the datapath controller, which retires it with a pop. It adds occupancy flags, a sticky overflow flag and optional load edge detection, so a held button no longer reloads every cycle.

## Interface
- WIDTH, 12: instruction word width in bits.
- DEPTH, 4: queue entries; power of two, ≥2.
- NSRC, 2: number of candidate sources; ≥2.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high; clears all state.
- load  in  1  load request from the debounced button.
- sel  in  $clog2(NSRC)  source select; entry k = d[k*WIDTH +: WIDTH].
- d  in  NSRC*WIDTH  packed candidate words.
- pop  in  1  consumer retires the head entry.
- clr_ovf  in  1  clears the overflow flag.
- q  out  WIDTH  head entry; 0 when empty.
- valid  out  1  queue non-empty.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH)+1  occupancy.
- ovf  out  1  sticky: a push was dropped.

## Operation
- push_req = load (level), or the load rising edge when IR_QUEUE_EDGE_EN is defined.
- sel ≥ NSRC selects source 0.
- push accepted when push_req && (!full || pop); writes d[sel] at the write pointer; wr_ptr increments modulo DEPTH.
- pop accepted when pop && valid; rd_ptr increments modulo DEPTH. A pop while empty is ignored and leaves state unchanged.
- Simultaneous accepted push and pop: count unchanged and both pointers advance. On an empty queue a simultaneous push and pop performs the push only, because pop is not accepted; q shows the new word on the next cycle.
- Dropped push (push_req && full && !pop): queue unchanged; ovf set.
- ovf clear: clr_ovf clears ovf. If a drop occurs in the same cycle as clr_ovf, set wins.
- Pointers wrap DEPTH-1 → 0. count is tracked explicitly, so full and empty are unambiguous.
- q = mem[rd_ptr] when valid, else 0. The output path is combinational from registered state.

## Timing
- Reset values: q=0, valid=0, full=0, count=0, ovf=0; pointers 0; edge-detect history 0; storage contents don't-care.
- rst asserted mid-operation flushes the queue on that edge; load and pop in that cycle are ignored.
- Load-to-q latency: 1 cycle when the queue was empty (edge N write, visible after edge N); otherwise the word appears when it reaches the head.
- Pop-to-next-head latency: 1 cycle.
- Flags update on the same edge as count.
- No combinational path from inputs to outputs.

## Configuration
- IR_QUEUE_EDGE_EN defined:
  - push_req = load && !load_q, where load_q is a 1-cycle registered copy of load.
  - A held load pushes exactly once; a new push needs load low for ≥1 cycle.
  - After reset, load already high pushes on the first edge after rst deasserts, because load_q resets to 0.
- IR_QUEUE_EDGE_EN undefined:
  - push_req = load.
  - Each cycle load is high attempts one push.
  - Matches the legacy level-load behaviour.

## Structure
- Package ir_pkg:
  - IR_WIDTH = 12 default constant.
  - typedef instr_t = logic [IR_WIDTH-1:0].
- Sub-module edge_det (clk, rst, in, rise):
  - Instantiated only under IR_QUEUE_EDGE_EN.
  - Reusable for other button inputs.
- Storage: DEPTH x WIDTH register array; no RAM inference required.

## Test plan
- Reset, idle: rst high 2 cycles, then idle → q=0, valid=0, count=0, full=0, ovf=0.
- Fill and drain: load pulses with sel=1, d1=0xA01,0xA02,0xA03,0xA04 → count=4, full=1; then pop ×4 → q reads 0xA01..0xA04 in order, each 1 cycle after the previous pop; valid=0 at the end.
- Overflow: push a 5th word 0xBBB while full without pop → ovf=1, count=4, head still 0xA01. Then clr_ovf → ovf=0. Repeat with clr_ovf and the drop in the same cycle → ovf=1.
- Full push+pop and wrap: with full, push 0xC00 together with pop → count=4, head advances; continue ≥2×DEPTH operations to exercise pointer wrap; order preserved.
- Edge mode (IR_QUEUE_EDGE_EN): hold load high 5 cycles, d0=0x123, sel=0 → count=1. Without the macro the same stimulus → count=4, ovf=1.
- Mid-operation reset and empty pop: rst during a push with count=2 → count=0, q=0 next cycle. Then pop on empty → no change. Then push+pop in the same cycle on empty → count=1.
